// File: rtl/cpu_muldiv_unit.sv
// rtl/cpu_muldiv_unit.sv - iterative RV32M-style multiply/divide unit with valid/ready handshakes
module cpu_muldiv_unit #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_div_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic              out_div_zero_q, out_div_zero_d;

    logic              in_signed_a, in_signed_b;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              in_div_zero, in_overflow;
    logic [XLEN:0]     sum_hi;
    logic [XLEN:0]     div_part, trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Operand signedness: MUL's low word is sign-agnostic, so it is treated as unsigned.
    assign in_signed_a = (in_op == 3'b001) || (in_op == 3'b010) ||
                         (in_op == 3'b100) || (in_op == 3'b110);
    assign in_signed_b = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
    assign sign_a      = in_signed_a & in_a[XLEN-1];
    assign sign_b      = in_signed_b & in_b[XLEN-1];
    assign abs_a       = sign_a ? (~in_a + 1'b1) : in_a;
    assign abs_b       = sign_b ? (~in_b + 1'b1) : in_b;
    assign in_div_zero = in_op[2] && (in_b == '0);
    assign in_overflow = in_op[2] && !in_op[0] && (in_a == MIN_NEG) && (in_b == '1);

    // Right-shifting shift-add: carry of the upper half is kept in sum_hi's top bit.
    assign sum_hi   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (a_q[0] ? {1'b0, b_q} : '0);
    assign div_part = {rem_q, a_q[XLEN-1]};
    assign trial    = div_part - {1'b0, b_q};

    assign prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
    assign quo_fix  = neg_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix  = neg_q ? (~rem_q + 1'b1) : rem_q;

    assign in_ready     = (state_q == S_IDLE) && !flush;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_div_zero = out_div_zero_q;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        prod_d         = prod_q;
        neg_d          = neg_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_result_d   = out_result_q;
        out_div_zero_d = out_div_zero_q;

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d   = in_op;
                        a_d    = abs_a;
                        b_d    = abs_b;
                        neg_d  = (in_op[2] && in_op[1]) ? sign_a : (sign_a ^ sign_b);
                        cnt_d  = '0;
                        prod_d = '0;
                        rem_d  = '0;
                        quo_d  = '0;
                        if (in_div_zero) begin
                            out_result_d   = in_op[1] ? in_a : '1;
                            out_div_zero_d = 1'b1;
                            out_valid_d    = 1'b1;
                            state_d        = S_DONE;
                        end else if (in_overflow) begin
                            out_result_d   = in_op[1] ? '0 : in_a;
                            out_div_zero_d = 1'b0;
                            out_valid_d    = 1'b1;
                            state_d        = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[2]) begin
                        a_d   = {a_q[XLEN-2:0], 1'b0};
                        quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                        rem_d = trial[XLEN] ? div_part[XLEN-1:0] : trial[XLEN-1:0];
                    end else begin
                        a_d    = {1'b0, a_q[XLEN-1:1]};
                        prod_d = {sum_hi, prod_q[XLEN-1:1]};
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    case (op_q)
                        3'b000:         out_result_d = prod_fix[XLEN-1:0];
                        3'b100, 3'b101: out_result_d = quo_fix;
                        3'b110, 3'b111: out_result_d = rem_fix;
                        default:        out_result_d = prod_fix[2*XLEN-1:XLEN];
                    endcase
                    out_div_zero_d = 1'b0;
                    out_valid_d    = 1'b1;
                    state_d        = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            prod_q         <= '0;
            neg_q          <= 1'b0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_div_zero_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            prod_q         <= prod_d;
            neg_q          <= neg_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_div_zero_q <= out_div_zero_d;
        end
    end

endmodule
